// File: rtl/noise_est_pkg.sv
// noise_est_pkg: scheduler state encoding and FIFO sizing helpers shared by the scheduler files
package noise_est_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SOF,
        FILL,
        BURST,
        GAP,
        DRAIN,
        DONE
    } sched_state_t;

    function automatic int fifo_aw(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int fifo_cw(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock power-of-two FIFO with combinational head read and occupancy count
module sync_fifo
    import noise_est_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic                      pop,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      full,
    output logic                      empty,
    output logic [fifo_cw(DEPTH)-1:0] count
);

    localparam int AW = fifo_aw(DEPTH);
    localparam int CW = fifo_cw(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_q;
    logic [AW-1:0]         rd_q;
    logic [CW-1:0]         cnt_q;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = cnt_q == CW'(DEPTH);
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_q];

    // pointers wrap naturally; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // storage needs no reset: flushing the pointers empties the FIFO
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/noise_estimation_scheduler.sv
// noise_estimation_scheduler: buffers a bursty pixel stream and replays it as gap-free blocks, then collects the noise result
module noise_estimation_scheduler
    import noise_est_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int TOTAL_SAMPLES  = 8,
    parameter int BLOCK_GAP      = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic [31:0]             cfg_blocks,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    ne_start_of_frame,
    output logic                    ne_start_data,
    output logic [DATA_WIDTH-1:0]   ne_data,
    output logic [31:0]             ne_blocks_per_frame,
    input  logic [2*DATA_WIDTH-1:0] ne_noise,
    input  logic                    ne_noise_ready,
    output logic                    noise_valid,
    input  logic                    noise_ready,
    output logic [2*DATA_WIDTH-1:0] noise_data,
    output logic                    timeout_err,
    output logic                    cfg_err,
    output logic                    busy
);

    localparam int DEPTH = 2 * TOTAL_SAMPLES;
    localparam int CW    = fifo_cw(DEPTH);

    sched_state_t            state_q, state_d;
    logic [31:0]             cfg_q, cfg_d;
    logic [31:0]             blk_q, blk_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [39:0]             acc_q, acc_d;
    logic [2*DATA_WIDTH-1:0] noise_q, noise_d;
    logic                    tmo_q, tmo_d;
    logic                    cerr_q, cerr_d;
    logic [DATA_WIDTH-1:0]   fifo_rdata;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic                    active;
    logic [39:0]             limit;

    assign active = state_q inside {SOF, FILL, BURST, GAP};
    assign limit  = 40'(cfg_q) * 40'(TOTAL_SAMPLES);
    assign s_ready = active && !fifo_full && (acc_q < limit);
    assign push   = s_valid && s_ready;
    assign pop    = (state_q == BURST) && !fifo_empty;

    assign ne_start_of_frame   = state_q == SOF;
    assign ne_start_data       = (state_q == BURST) && (cnt_q == '0);
    assign ne_data             = pop ? fifo_rdata : '0;
    assign ne_blocks_per_frame = cfg_q;
    assign noise_valid         = state_q == DONE;
    assign noise_data          = noise_q;
    assign timeout_err         = tmo_q;
    assign cfg_err             = cerr_q;
    assign busy                = state_q != IDLE;

    sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .wdata(s_data),
        .pop  (pop),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    // state, counters and result register; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            blk_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            noise_q <= '0;
            tmo_q   <= 1'b0;
            cerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            blk_q   <= blk_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            noise_q <= noise_d;
            tmo_q   <= tmo_d;
            cerr_q  <= cerr_d;
        end
    end

    // frame sequencing; cnt_q is reused as burst index, gap timer and drain timer
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        blk_d   = blk_q;
        cnt_d   = cnt_q;
        acc_d   = push ? acc_q + 40'd1 : acc_q;
        noise_d = noise_q;
        tmo_d   = tmo_q;
        cerr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start && cfg_blocks != '0) begin
                    cfg_d   = cfg_blocks;
                    blk_d   = '0;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = SOF;
                end else if (frame_start) begin
                    cerr_d = 1'b1;
                end
            end
            SOF: state_d = FILL;
            FILL: begin
                if (fifo_count >= CW'(TOTAL_SAMPLES)) begin
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == 32'(TOTAL_SAMPLES - 1)) begin
                    cnt_d   = '0;
                    blk_d   = blk_q + 32'd1;
                    state_d = (blk_q + 32'd1 == cfg_q) ? DRAIN : (BLOCK_GAP == 0 ? FILL : GAP);
                end
            end
            GAP: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == 32'(BLOCK_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 32'd1;
                if (ne_noise_ready) begin
                    noise_d = ne_noise;
                    tmo_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    noise_d = '0;
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: state_d = noise_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_noise_estimation_scheduler.sv
// tb_noise_estimation_scheduler: directed frames with a queue scoreboard checked by a negedge monitor
module tb_noise_estimation_scheduler;

    localparam int DW   = 8;
    localparam int TS   = 8;
    localparam int GAPC = 2;
    localparam int TMO  = 16;

    typedef struct packed {
        logic [2*DW-1:0] d;
        logic            t;
    } res_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            frame_start = 1'b0;
    logic [31:0]     cfg_blocks = '0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [DW-1:0]   s_data = '0;
    logic            ne_start_of_frame;
    logic            ne_start_data;
    logic [DW-1:0]   ne_data;
    logic [31:0]     ne_blocks_per_frame;
    logic [2*DW-1:0] ne_noise = '0;
    logic            ne_noise_ready = 1'b0;
    logic            noise_valid;
    logic            noise_ready = 1'b1;
    logic [2*DW-1:0] noise_data;
    logic            timeout_err;
    logic            cfg_err;
    logic            busy;

    logic [DW-1:0] exp_pix[$];
    res_t          exp_res[$];
    int total = 0, bad = 0, cyc = 0;
    int sof_cnt = 0, cerr_cnt = 0, bursts_seen = 0, bidx = 0, idle = 0, sof_cyc = 0, first_sd = 0;

    noise_estimation_scheduler #(
        .DATA_WIDTH    (DW),
        .TOTAL_SAMPLES (TS),
        .BLOCK_GAP     (GAPC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .frame_start        (frame_start),
        .cfg_blocks         (cfg_blocks),
        .s_valid            (s_valid),
        .s_ready            (s_ready),
        .s_data             (s_data),
        .ne_start_of_frame  (ne_start_of_frame),
        .ne_start_data      (ne_start_data),
        .ne_data            (ne_data),
        .ne_blocks_per_frame(ne_blocks_per_frame),
        .ne_noise           (ne_noise),
        .ne_noise_ready     (ne_noise_ready),
        .noise_valid        (noise_valid),
        .noise_ready        (noise_ready),
        .noise_data         (noise_data),
        .timeout_err        (timeout_err),
        .cfg_err            (cfg_err),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, a, e);
        end
    endfunction

    // monitor: burst pixels against the pixel queue, results against the result queue
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            bidx = 0;
            bursts_seen = 0;
            idle = 0;
        end else begin
            if (ne_start_of_frame) begin
                sof_cnt++;
                bursts_seen = 0;
                sof_cyc = cyc;
            end
            if (cfg_err) cerr_cnt++;
            if (bidx == 0 && ne_start_data) begin
                if (bursts_seen == 0) first_sd = cyc - sof_cyc;
                else chk("gap_idle", 64'(idle >= GAPC), 1);
            end
            if (bidx != 0 || ne_start_data) begin
                if (bidx != 0) chk("start_data_extra", 64'(ne_start_data), 0);
                if (exp_pix.size() == 0) chk("pix_unexpected", 64'(ne_data), 64'hFFFF);
                else chk("pix", 64'(ne_data), 64'(exp_pix.pop_front()));
                bidx = (bidx + 1) % TS;
                if (bidx == 0) begin
                    bursts_seen++;
                    idle = 0;
                end
            end else begin
                idle++;
                chk("idle_data", 64'(ne_data), 0);
            end
            if (noise_valid) begin
                if (exp_res.size() == 0) chk("res_unexpected", 64'(noise_data), 64'hFFFFF);
                else begin
                    chk("noise_data", 64'(noise_data), 64'(exp_res[0].d));
                    chk("timeout_err", 64'(timeout_err), 64'(exp_res[0].t));
                    if (noise_ready) void'(exp_res.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int cfg);
        ne_noise_ready = 1'b1;
        ne_noise = 16'hDEAD;
        frame_start = 1'b1;
        cfg_blocks = 32'(cfg);
        tick();
        frame_start = 1'b0;
    endtask

    task automatic feed(input int base, input int n, input bit rnd);
        logic ok;
        for (int i = 0; i < n; i++) begin
            if (rnd) while ($urandom_range(1) == 0) tick();
            s_valid = 1'b1;
            s_data = DW'(base + i);
            exp_pix.push_back(DW'(base + i));
            ok = 1'b0;
            for (int t = 0; t < 300; t++) begin
                ok = s_ready;
                tick();
                if (ok) break;
            end
            chk("accept", 64'(ok), 1);
            s_valid = 1'b0;
        end
    endtask

    task automatic finish_frame(input int cfg, input int ready_at, input logic [2*DW-1:0] val, input int hold);
        int n;
        res_t r;
        n = 0;
        while (bursts_seen < cfg && n < 3000) begin
            tick();
            n++;
        end
        chk("bursts_done", 64'(bursts_seen), 64'(cfg));
        ne_noise_ready = 1'b0;
        r.d = (ready_at >= 0) ? val : '0;
        r.t = ready_at < 0;
        exp_res.push_back(r);
        noise_ready = (hold == 0);
        n = 0;
        while (!noise_valid && n < 100) begin
            if (n == ready_at) begin
                ne_noise_ready = 1'b1;
                ne_noise = val;
            end
            tick();
            ne_noise_ready = 1'b0;
            n++;
        end
        chk("drain_latency", 64'(n), 64'((ready_at >= 0) ? ready_at + 1 : TMO));
        repeat (hold) tick();
        noise_ready = 1'b1;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("busy_clear", 64'(busy), 0);
        chk("blocks_latched", 64'(ne_blocks_per_frame), 64'(cfg));
        chk("res_consumed", 64'(exp_res.size()), 0);
        chk("pix_consumed", 64'(exp_pix.size()), 0);
    endtask

    task automatic run_frame(input int cfg, input int base, input bit rnd, input int ready_at,
                             input logic [2*DW-1:0] val, input int hold, input bit poke);
        int s0, e0, n;
        s0 = sof_cnt;
        e0 = cerr_cnt;
        start_frame(cfg);
        feed(base, cfg * TS, rnd);
        if (poke) begin
            n = 0;
            while (!ne_start_data && n < 100) begin
                tick();
                n++;
            end
            chk("reach_burst", 64'(ne_start_data), 1);
            frame_start = 1'b1;
            cfg_blocks = 32'd5;
            tick();
            frame_start = 1'b0;
        end
        finish_frame(cfg, ready_at, val, hold);
        chk("sof_pulses", 64'(sof_cnt - s0), 1);
        chk("no_cfg_err", 64'(cerr_cnt - e0), 0);
        if (!rnd) chk("first_burst_lat", 64'(first_sd), 9);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int e0, n;
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_outputs", 64'({ne_start_of_frame, ne_start_data, ne_data, ne_blocks_per_frame, noise_valid,
                                  noise_data, timeout_err, cfg_err, busy, s_ready}), 0);
        rst = 1'b0;
        tick();
        run_frame(4, 0, 0, 0, 16'hA5A5, 0, 0);
        run_frame(4, 0, 1, 3, 16'h5A5A, 0, 0);
        run_frame(2, 32, 0, 5, 16'h1234, 10, 0);
        run_frame(1, 64, 0, -1, 16'h0000, 0, 0);
        e0 = cerr_cnt;
        frame_start = 1'b1;
        cfg_blocks = '0;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("busy_cfg0", 64'(busy), 0);
            tick();
        end
        chk("cfg_err_pulses", 64'(cerr_cnt - e0), 1);
        run_frame(1, 80, 0, -1, 16'h0000, 0, 1);
        start_frame(3);
        feed(50, 16, 0);
        n = 0;
        while (!(bursts_seen == 1 && bidx >= 3) && n < 200) begin
            tick();
            n++;
        end
        chk("reach_mid_burst", 64'(n < 200), 1);
        rst = 1'b1;
        exp_pix.delete();
        tick();
        chk("rst_mid_outputs", 64'({ne_start_of_frame, ne_start_data, ne_data, ne_blocks_per_frame, noise_valid,
                                    noise_data, timeout_err, cfg_err, busy, s_ready}), 0);
        rst = 1'b0;
        tick();
        run_frame(1, 100, 0, 2, 16'hBEEF, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
